// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit unsigned multu/divu unit driving HI/LO through one shared adder
module Adder_cout (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic [31:0] add_result,
    output logic        cout
);
    logic [31:0] w_b;
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;
    logic [8:0]  w_cg;
    // Nibble-level carry lookahead; in subtract mode cout reports a borrow
    always_comb begin
        w_b = B ^ {32{sub}};
        w_g = A & w_b;
        w_p = A ^ w_b;
        w_cg[0] = sub;
        for (int k = 0; k < 8; k++) begin
            w_cg[k+1] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]) | (&w_p[4*k+2 +: 2] & w_g[4*k+1])
                      | (&w_p[4*k+1 +: 3] & w_g[4*k]) | (&w_p[4*k +: 4] & w_cg[k]);
        end
        w_c[0] = sub;
        for (int i = 0; i < 32; i++) begin
            w_c[i+1] = (i % 4 == 3) ? w_cg[i/4+1] : (w_g[i] | (w_p[i] & w_c[i]));
        end
        add_result = w_p ^ w_c[31:0];
        cout = w_c[32] ^ sub;
    end
endmodule

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        w_div;
    logic [31:0] w_a;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_ok;
    logic [32:0] w_ms;
    logic [31:0] w_acc_n;
    logic [31:0] w_q_n;

    Adder_cout u_add (.A(w_a), .B(r_m), .sub(w_div), .add_result(w_sum), .cout(w_cout));

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_div = r_state == DIV;
        w_a = w_div ? {r_acc[30:0], r_q[31]} : r_acc;
        w_ok = r_acc[31] | ~w_cout;
        w_ms = r_q[0] ? {w_cout, w_sum} : {1'b0, r_acc};
        w_acc_n = w_div ? (w_ok ? w_sum : w_a) : w_ms[32:1];
        w_q_n = w_div ? {r_q[30:0], w_ok} : {w_ms[0], r_q[31:1]};
    end

    // Control FSM; HI/LO only move on a direct write while idle or on the final iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == IDLE || r_state == DONE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
            r_done <= 1'b0;
            r_busy <= start;
            r_state <= start ? (op ? DIV : MUL) : IDLE;
            if (start) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_q   <= op ? inA : inB;
                r_m   <= op ? inB : inA;
            end
        end else begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_hi    <= w_acc_n;
                r_lo    <= w_q_n;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
